// File: rtl/motor_pkg.sv
// Shared definitions for the line-follower motor driver: channel state
// encoding, the PID bus width and the symmetric saturation helper.
package motor_pkg;

    // Width of the signed correction coming from the PID controller.
    localparam int PID_W = 11;

    // Width used for the speed target arithmetic (base +/- correction).
    localparam int SUM_W = 13;

    typedef enum logic [1:0] {
        ST_FWD  = 2'd0,
        ST_REV  = 2'd1,
        ST_DEAD = 2'd2
    } chan_state_t;

    // Clamp a signed value into [-limit, +limit]; limit must be non-negative.
    function automatic logic signed [SUM_W-1:0] saturate(
        input logic signed [SUM_W-1:0] value,
        input logic signed [SUM_W-1:0] limit
    );
        if (value > limit) begin
            return limit;
        end else if (value < -limit) begin
            return -limit;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: soft ramp of the applied duty, direction FSM with a
// dead interval on reversal, and the registered H-bridge pin drivers.
// Optional build macro MOTOR_BRAKE_EN: idle bridge is short-braked
// (both pins high) instead of coasting (both pins low).
// PWM_BITS must leave two guard bits inside SUM_W (PWM_BITS <= SUM_W-3).
module motor_channel
    import motor_pkg::*;
#(
    parameter int PWM_BITS     = 10,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [PWM_BITS-1:0]        counter,
    input  logic signed [SUM_W-1:0]    target,
    output logic                       in1,
    output logic                       in2,
    output logic signed [PWM_BITS:0]   duty
);

    localparam int DW        = PWM_BITS + 1;
    localparam int DMAX      = (1 << PWM_BITS) - 1;
    localparam int STEP_LIM  = (RAMP_STEP >= DMAX) ? DMAX : ((RAMP_STEP < 1) ? 1 : RAMP_STEP);
    localparam int DEAD_LOAD = (DEAD_PERIODS > 1) ? DEAD_PERIODS - 1 : 0;
    localparam int CNT_W     = (DEAD_LOAD > 0) ? $clog2(DEAD_LOAD + 1) : 1;

    localparam logic signed [SUM_W-1:0] STEP_X    = SUM_W'(STEP_LIM);
    localparam logic [CNT_W-1:0]        DEAD_INIT = CNT_W'(DEAD_LOAD);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);

`ifdef MOTOR_BRAKE_EN
    localparam logic IDLE_LEVEL = 1'b1;
`else
    localparam logic IDLE_LEVEL = 1'b0;
`endif

    chan_state_t             state;
    chan_state_t             prev_dir;
    logic signed [DW-1:0]    applied;
    logic [CNT_W-1:0]        dead_cnt;

    logic signed [SUM_W-1:0] applied_x;
    logic signed [SUM_W-1:0] diff;
    logic signed [SUM_W-1:0] step;
    logic signed [SUM_W-1:0] stepped;
    logic signed [DW-1:0]    fwd_next;
    logic signed [DW-1:0]    rev_next;
    logic                    tgt_neg;
    logic                    tgt_pos;
    logic [DW-1:0]           mag;
    logic                    pwm_on;
    logic                    idle;

    // Rate-limited step toward the target, then clamped so the applied duty
    // can never cross zero while the bridge is still in the old direction.
    always_comb begin
        applied_x = {{(SUM_W-DW){applied[DW-1]}}, applied};
        diff      = target - applied_x;
        if (diff > STEP_X) begin
            step = STEP_X;
        end else if (diff < -STEP_X) begin
            step = -STEP_X;
        end else begin
            step = diff;
        end
        stepped  = applied_x + step;
        fwd_next = stepped[SUM_W-1] ? '0 : stepped[DW-1:0];
        rev_next = (!stepped[SUM_W-1] && (stepped != '0)) ? '0 : stepped[DW-1:0];
        tgt_neg  = target[SUM_W-1];
        tgt_pos  = !target[SUM_W-1] && (target != '0);
    end

    // Direction FSM, dead-period counter and applied duty, all advanced on the period tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FWD;
            prev_dir <= ST_FWD;
            applied  <= '0;
            dead_cnt <= '0;
        end else if (tick) begin
            case (state)
                ST_FWD: begin
                    if ((applied == '0) && tgt_neg) begin
                        state    <= ST_DEAD;
                        prev_dir <= ST_FWD;
                        dead_cnt <= DEAD_INIT;
                    end else begin
                        applied <= fwd_next;
                    end
                end
                ST_REV: begin
                    if ((applied == '0) && tgt_pos) begin
                        state    <= ST_DEAD;
                        prev_dir <= ST_REV;
                        dead_cnt <= DEAD_INIT;
                    end else begin
                        applied <= rev_next;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt == '0) begin
                        if (tgt_pos) begin
                            state   <= ST_FWD;
                            applied <= fwd_next;
                        end else if (tgt_neg) begin
                            state   <= ST_REV;
                            applied <= rev_next;
                        end else begin
                            state   <= prev_dir;
                            applied <= '0;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - CNT_ONE;
                        applied  <= '0;
                    end
                end
                default: begin
                    state   <= ST_FWD;
                    applied <= '0;
                end
            endcase
        end
    end

    // Compare the free-running counter against the duty magnitude.
    always_comb begin
        mag    = applied[DW-1] ? -applied : applied;
        pwm_on = ({1'b0, counter} < mag);
        idle   = (state == ST_DEAD) || (applied == '0);
    end

    // Registered pin drivers; only one pin can carry PWM for a given state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1 <= 1'b0;
            in2 <= 1'b0;
        end else if (idle) begin
            in1 <= IDLE_LEVEL;
            in2 <= IDLE_LEVEL;
        end else if (state == ST_REV) begin
            in1 <= 1'b0;
            in2 <= pwm_on;
        end else begin
            in1 <= pwm_on;
            in2 <= 1'b0;
        end
    end

    assign duty = applied;

endmodule

// File: rtl/motor_pwm_driver.sv
// Differential motor drive for the line follower: converts the signed PID
// correction into left/right speed targets and drives two H-bridges with
// fixed-frequency PWM through two motor_channel instances.
// Optional build macro MOTOR_BRAKE_EN (see motor_channel).
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PWM_BITS     = 10,
    parameter int BASE_SPEED   = 600,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic signed [PID_W-1:0]   pid_output,
    output logic                      ml_in1,
    output logic                      ml_in2,
    output logic                      mr_in1,
    output logic                      mr_in2,
    output logic signed [PWM_BITS:0]  duty_l,
    output logic signed [PWM_BITS:0]  duty_r,
    output logic                      period_tick
);

    localparam logic [PWM_BITS-1:0]     CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0]     CNT_ONE = PWM_BITS'(1);
    localparam logic signed [SUM_W-1:0] DMAX_X  = SUM_W'((1 << PWM_BITS) - 1);
    localparam logic signed [SUM_W-1:0] BASE_X  = SUM_W'(BASE_SPEED);

    logic [PWM_BITS-1:0]     counter;
    logic signed [SUM_W-1:0] pid_x;
    logic signed [SUM_W-1:0] target_l;
    logic signed [SUM_W-1:0] target_r;

    // Free-running PWM counter shared by both channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else begin
            counter <= counter + CNT_ONE;
        end
    end

    assign period_tick = (counter == CNT_MAX);

    // Speed targets: base speed steered by the correction, saturated, zero when disabled.
    always_comb begin
        pid_x = {{(SUM_W-PID_W){pid_output[PID_W-1]}}, pid_output};
        if (enable) begin
            target_l = saturate(BASE_X + pid_x, DMAX_X);
            target_r = saturate(BASE_X - pid_x, DMAX_X);
        end else begin
            target_l = '0;
            target_r = '0;
        end
    end

    motor_channel #(
        .PWM_BITS     (PWM_BITS),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_left (
        .clk     (clk),
        .rst     (rst),
        .tick    (period_tick),
        .counter (counter),
        .target  (target_l),
        .in1     (ml_in1),
        .in2     (ml_in2),
        .duty    (duty_l)
    );

    motor_channel #(
        .PWM_BITS     (PWM_BITS),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_right (
        .clk     (clk),
        .rst     (rst),
        .tick    (period_tick),
        .counter (counter),
        .target  (target_r),
        .in1     (mr_in1),
        .in2     (mr_in2),
        .duty    (duty_r)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver. Instance A uses a short 256-cycle
// period with the soft ramp active; instance B uses the default 1024-cycle
// period with the ramp disabled for steering and reversal scenarios.
module tb_motor_pwm_driver;

`ifdef MOTOR_BRAKE_EN
    localparam int BRK = 1;
`else
    localparam int BRK = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b;
    logic signed [10:0] pid_a, pid_b;

    logic ml_in1_a, ml_in2_a, mr_in1_a, mr_in2_a, tick_a;
    logic ml_in1_b, ml_in2_b, mr_in1_b, mr_in2_b, tick_b;
    logic signed [8:0]  duty_l_a, duty_r_a;
    logic signed [10:0] duty_l_b, duty_r_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_BITS(8), .BASE_SPEED(200), .RAMP_STEP(8), .DEAD_PERIODS(2)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .pid_output(pid_a),
        .ml_in1(ml_in1_a), .ml_in2(ml_in2_a), .mr_in1(mr_in1_a), .mr_in2(mr_in2_a),
        .duty_l(duty_l_a), .duty_r(duty_r_a), .period_tick(tick_a)
    );

    motor_pwm_driver #(
        .PWM_BITS(10), .BASE_SPEED(600), .RAMP_STEP(1023), .DEAD_PERIODS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .pid_output(pid_b),
        .ml_in1(ml_in1_b), .ml_in2(ml_in2_b), .mr_in1(mr_in1_b), .mr_in2(mr_in2_b),
        .duty_l(duty_l_b), .duty_r(duty_r_b), .period_tick(tick_b)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input logic en, input int pid);
        if (sel_b) begin
            en_b  = en;
            pid_b = 11'(pid);
        end else begin
            en_a  = en;
            pid_a = 11'(pid);
        end
    endtask

    // Leaves the bench at the negedge of counter == 0 of the next period.
    task automatic nextPeriodA();
        int n = 0;
        while (tick_a !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (tick_a !== 1'b1) checkOutput("tick_a_timeout", int'(tick_a), 1);
        @(negedge clk);
    endtask

    task automatic nextPeriodB();
        int n = 0;
        while (tick_b !== 1'b1 && n < 2200) begin
            @(negedge clk);
            n++;
        end
        if (tick_b !== 1'b1) checkOutput("tick_b_timeout", int'(tick_b), 1);
        @(negedge clk);
    endtask

    // Counts high cycles over one whole period; ends on the tick negedge.
    task automatic countA(output int l1, output int l2, output int r1, output int r2);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < 256; i++) begin
            l1 += int'(ml_in1_a); l2 += int'(ml_in2_a);
            r1 += int'(mr_in1_a); r2 += int'(mr_in2_a);
            if (i < 255) @(negedge clk);
        end
    endtask

    task automatic countB(output int l1, output int l2, output int r1, output int r2);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < 1024; i++) begin
            l1 += int'(ml_in1_b); l2 += int'(ml_in2_b);
            r1 += int'(mr_in1_b); r2 += int'(mr_in2_b);
            if (i < 1023) @(negedge clk);
        end
    endtask

    initial begin
        int l1, l2, r1, r2, n;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);

        // reset state
        checkOutput("reset_pins_a", int'({ml_in1_a, ml_in2_a, mr_in1_a, mr_in2_a}), 0);
        checkOutput("reset_pins_b", int'({ml_in1_b, ml_in2_b, mr_in1_b, mr_in2_b}), 0);
        checkOutput("reset_duty_l_a", int'(duty_l_a), 0);
        checkOutput("reset_duty_r_b", int'(duty_r_b), 0);
        checkOutput("reset_tick_a", int'(tick_a), 0);
        rst = 1'b1;

        // soft ramp up on instance A: +8 per period up to 200
        applyStimulus(1'b0, 1'b1, 0);
        nextPeriodA();
        checkOutput("ramp_first_l", int'(duty_l_a), 8);
        checkOutput("ramp_first_r", int'(duty_r_a), 8);
        repeat (24) nextPeriodA();
        checkOutput("ramp_full_l", int'(duty_l_a), 200);
        checkOutput("ramp_full_r", int'(duty_r_a), 200);
        countA(l1, l2, r1, r2);
        checkOutput("ramp_hi_ml_in1", l1, 200);
        checkOutput("ramp_hi_mr_in1", r1, 200);
        checkOutput("ramp_hi_in2", l2 + r2, 0);

        // enable drop: ramps down by 8 per period, no reversal
        applyStimulus(1'b0, 1'b0, 0);
        nextPeriodA();
        checkOutput("drop_first_l", int'(duty_l_a), 192);
        repeat (24) nextPeriodA();
        checkOutput("drop_zero_l", int'(duty_l_a), 0);
        checkOutput("drop_zero_r", int'(duty_r_a), 0);
        countA(l1, l2, r1, r2);
        checkOutput("drop_idle_ml_in1", l1, 255 * BRK);
        checkOutput("drop_idle_ml_in2", l2, 255 * BRK);
        applyStimulus(1'b0, 1'b1, 0);
        nextPeriodA();
        checkOutput("drop_still_fwd_l", int'(duty_l_a), 8);

        // no-ramp steering on instance B
        applyStimulus(1'b1, 1'b1, 300);
        nextPeriodB();
        checkOutput("steer_duty_l", int'(duty_l_b), 900);
        checkOutput("steer_duty_r", int'(duty_r_b), 300);
        countB(l1, l2, r1, r2);
        checkOutput("steer_hi_ml_in1", l1, 900 + BRK);
        checkOutput("steer_hi_mr_in1", r1, 300 + BRK);
        checkOutput("steer_hi_in2", l2 + r2, 2 * BRK);

        // mid-period pid change must wait for the tick
        nextPeriodB();
        repeat (100) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1000);
        repeat (100) @(negedge clk);
        checkOutput("midperiod_hold_l", int'(duty_l_b), 900);
        checkOutput("midperiod_hold_r", int'(duty_r_b), 300);

        // reversal of the right motor: tr = -400, tl saturates at 1023
        nextPeriodB();
        checkOutput("rev_t1_duty_l", int'(duty_l_b), 1023);
        checkOutput("rev_t1_duty_r", int'(duty_r_b), 0);
        nextPeriodB();
        checkOutput("rev_t2_duty_r", int'(duty_r_b), 0);
        countB(l1, l2, r1, r2);
        checkOutput("dead1_mr_in1", r1, 1024 * BRK);
        checkOutput("dead1_mr_in2", r2, 1024 * BRK);
        checkOutput("dead1_ml_in1", l1, 1023);
        checkOutput("dead1_ml_in2", l2, 0);
        nextPeriodB();
        checkOutput("rev_t3_duty_r", int'(duty_r_b), 0);
        countB(l1, l2, r1, r2);
        checkOutput("dead2_mr_in2", r2, 1024 * BRK);
        nextPeriodB();
        checkOutput("rev_t4_duty_r", int'(duty_r_b), -400);
        countB(l1, l2, r1, r2);
        checkOutput("rev_hi_mr_in2", r2, 400 + BRK);
        checkOutput("rev_hi_mr_in1", r1, BRK);

        // asynchronous reset in the middle of a period
        nextPeriodB();
        repeat (500) @(negedge clk);
        checkOutput("prereset_ml_in1", int'(ml_in1_b), 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_pins_b", int'({ml_in1_b, ml_in2_b, mr_in1_b, mr_in2_b}), 0);
        checkOutput("async_pins_a", int'({ml_in1_a, ml_in2_a, mr_in1_a, mr_in2_a}), 0);
        checkOutput("async_duty_l_b", int'(duty_l_b), 0);
        checkOutput("async_duty_r_b", int'(duty_r_b), 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (tick_b !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("restart_tick_delay", n, 1023);
        checkOutput("restart_duty_l", int'(duty_l_b), 0);
        nextPeriodB();
        checkOutput("restart_first_l", int'(duty_l_b), 1023);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Consumer end of the PID controller's `pid_output` bus; turns the signed correction into differential drive for the left and right DC motors of the line follower.
- Per motor it computes a signed speed target, rate-limits it (soft ramp), and enforces a dead interval on direction reversal.
- Drives the H-bridge IN1/IN2 pins with fixed-frequency PWM.

Parameters:
- PWM_BITS, 10: PWM counter width; period = 2^PWM_BITS clk cycles; max duty DMAX = 2^PWM_BITS-1.
- BASE_SPEED, 600: signed forward speed added to / subtracted from the correction.
- RAMP_STEP, 8: max change of applied duty per PWM period; a value ≥ DMAX disables the ramp.
- DEAD_PERIODS, 2: whole PWM periods with the bridge off on a direction reversal; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- enable  in  1  drive enable (switch); low ramps both motors to 0.
- pid_output  in  11  signed two's-complement correction; positive steers right.
- ml_in1, ml_in2  out  1 each  left H-bridge inputs.
- mr_in1, mr_in2  out  1 each  right H-bridge inputs.
- duty_l, duty_r  out  PWM_BITS+1 each  signed applied duty, for debug/LEDs.
- period_tick  out  1  one-cycle pulse on the last cycle of each PWM period.

Behaviour:
- Reset (rst low, async): counter = 0; both channels in FWD with applied duty 0; all in pins 0; duty_l/duty_r = 0; period_tick = 0.
- Counter
  - Free-runs 0..DMAX and wraps.
  - period_tick = 1 when counter == DMAX.
- Target update, on a period_tick cycle only:
  - Sample pid_output.
  - tl = BASE_SPEED + pid; tr = BASE_SPEED - pid, computed in 13-bit signed.
  - Saturate each to [-DMAX, +DMAX].
  - If enable = 0, both targets = 0.
  - pid_output changes mid-period are ignored until the next tick.
- Ramp, per channel, on tick: d = target - applied; applied += d clamped to ±RAMP_STEP.
  - Zero-crossing rule: if applied and target have opposite signs, the result is clamped at 0. Applied never changes sign in one step.
- Channel FSM (one per motor): FWD, REV, DEAD.
  - FWD: in1 = pwm, in2 = 0.
  - REV: in1 = 0, in2 = pwm.
  - pwm = (counter < |applied|). Duty 0 gives a constant 0; DMAX gives high for DMAX of 2^PWM_BITS cycles.
  - FWD → DEAD: on a tick with applied == 0 and target < 0.
  - REV → DEAD: on a tick with applied == 0 and target > 0.
  - DEAD: in1 = in2 = 0. Stays DEAD_PERIODS full periods (period counter loaded on entry). Then, on a tick, goes to FWD or REV according to the sign of the target at that tick. If the target is 0 at that tick, returns to the previous direction. Applied stays 0 throughout DEAD.
  - Target back to 0 while in DEAD: the period count still completes (no early exit).
- Latency:
  - Applied duty and the new state become effective on the cycle after the tick (counter == 0).
  - in pins are registered. Each pin reflects the counter compare of the previous cycle (1-cycle latency).
- Glitch-free outputs: in1 and in2 are never both 1 (except under the Optional Feature), including across state changes.
- Simultaneous events: enable falling together with a reversal request means target = 0, so there is no DEAD entry; the channel ramps to 0.
- Reset mid-period: outputs drop immediately; operation restarts with a full period from counter 0.

Optional Feature:
- Macro MOTOR_BRAKE_EN.
  - Defined: in DEAD, and in FWD/REV whenever applied == 0, both in1 and in2 = 1 (active short-brake).
  - Undefined: both 0 (coast).
- All other behaviour is identical.

Decomposition:
- Package motor_pkg holds:
  - FSM state encoding (ST_FWD, ST_REV, ST_DEAD);
  - the saturate function;
  - the shared width constant for pid_output (11).
- One sub-module, motor_channel, instantiated twice. It contains the ramp, FSM, dead counter and output register. It takes the shared counter, the tick and a signed target.
- Top level holds the counter, the target arithmetic and saturation.

Test Plan:
- Ramp: defaults, enable = 1, pid = 0 → after 75 ticks duty_l = duty_r = 600. PWM high count per period = 600 on ml_in1 and mr_in1; in2 pins stay 0.
- No-ramp steering: RAMP_STEP = 1023, pid = +300 → next period duty_l = 900, duty_r = 300. pid = +1023 → duty_l = 1023 (saturated), duty_r = -423 only after passing 0 and DEAD.
- Reversal: RAMP_STEP = 1023, right channel applied +300, pid = +1000 (tr = -400):
  - tick 1: duty_r = 0;
  - tick 2: enters DEAD, mr pins 0 for 2 periods;
  - next tick: REV, mr_in2 high 400 cycles per period, mr_in1 = 0.
- Enable drop: running at 600, enable → 0 → duty decreases by 8 per tick to 0, no DEAD entry. pid changes mid-period have no effect until period_tick.
- Reset mid-period: assert rst low at counter = 500 → all pins 0 within the same cycle (async). After release, counter restarts at 0 and duty is 0.
- MOTOR_BRAKE_EN build: repeat the reversal test → during DEAD, mr_in1 = mr_in2 = 1. Without the macro → both 0.
